// File: rtl/paged_stream_reader.sv
// -----------------------------------------------------------------------------
// paged_stream_reader
//
// Accepts page base addresses on an AXI-Stream slave, breaks each page into
// fixed-length INCR bursts on an AXI4 read-address channel, and forwards the
// returned read data on an AXI-Stream master with full backpressure.
// Before a burst is issued, room for all of its beats is reserved in the output
// FIFO. This lets R-channel data always be accepted (rready is tied high).
//
// Optional feature (compile-time macro):
//   PAGED_STREAM_READER_RRESP_CHECK_EN
//     defined   : any R beat with rresp != 0 sets the sticky rd_error flag.
//     undefined : rresp is ignored and rd_error is tied low.
//
// Ports
//   aclk, reset            clock; asynchronous active-high reset
//   s_axis_*               page base address in (tdata[ADDR_WIDTH-1:0]),
//                          tlast marks the final page of a transfer
//   m_axis_*               page data out, tlast on the last beat of a
//                          tlast-tagged page
//   m_mem_axi_ar*          AXI4 read-address channel (constant ID 0)
//   m_mem_axi_r*           AXI4 read-data channel (rready constant 1)
//   rd_error               sticky read-response error flag
// -----------------------------------------------------------------------------
module paged_stream_reader #(
  parameter int STREAM_WIDTH    = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int PAGE_SIZE       = 2048,
  parameter int BURST_BEATS     = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    aclk,
  input  logic                    reset,

  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,

  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [STREAM_WIDTH-1:0] m_axis_tdata,

  output logic [ID_WIDTH-1:0]     m_mem_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_mem_axi_araddr,
  output logic [7:0]              m_mem_axi_arlen,
  output logic [2:0]              m_mem_axi_arsize,
  output logic [1:0]              m_mem_axi_arburst,
  output logic                    m_mem_axi_arlock,
  output logic [3:0]              m_mem_axi_arcache,
  output logic [2:0]              m_mem_axi_arprot,
  output logic                    m_mem_axi_arvalid,
  input  logic                    m_mem_axi_arready,

  input  logic [ID_WIDTH-1:0]     m_mem_axi_rid,
  input  logic [STREAM_WIDTH-1:0] m_mem_axi_rdata,
  input  logic [1:0]              m_mem_axi_rresp,
  input  logic                    m_mem_axi_rlast,
  input  logic                    m_mem_axi_rvalid,
  output logic                    m_mem_axi_rready,

  output logic                    rd_error
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int BEAT_BYTES  = STREAM_WIDTH / 8;
  localparam int BURST_BYTES = BURST_BEATS * BEAT_BYTES;
  localparam int DEPTH       = MAX_OUTSTANDING * BURST_BEATS;
  localparam int OFF_W       = $clog2(PAGE_SIZE) + 1;
  localparam int CRED_W      = $clog2(DEPTH + BURST_BEATS + 1);
  localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int TAG_PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TAG_CNT_W   = $clog2(MAX_OUTSTANDING + 1);

  // ---------------------------------------------------------------------------
  // Constant AR / R fields
  // ---------------------------------------------------------------------------
  assign m_mem_axi_arid    = '0;
  assign m_mem_axi_arlen   = 8'(BURST_BEATS - 1);
  assign m_mem_axi_arsize  = 3'($clog2(BEAT_BYTES));
  assign m_mem_axi_arburst = 2'b01;
  assign m_mem_axi_arlock  = 1'b0;
  assign m_mem_axi_arcache = 4'b0000;
  assign m_mem_axi_arprot  = 3'b000;
  assign m_mem_axi_rready  = 1'b1;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_AR = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [OFF_W-1:0]        off_reg;
  logic                    page_last_reg;
  logic [ADDR_WIDTH-1:0]   araddr_reg;
  logic [CRED_W-1:0]       credits_reg;
  logic [CRED_W-1:0]       credits_next;

  logic [OFF_W-1:0]        off_plus;
  logic                    page_end;
  logic                    can_reserve;
  logic                    accept;
  logic                    reserve;
  logic                    ar_done;
  logic                    tag_full;
  logic                    out_hs;

  assign off_plus    = off_reg + OFF_W'(BURST_BYTES);
  assign page_end    = (off_plus == OFF_W'(PAGE_SIZE));
  assign can_reserve = ((credits_reg + CRED_W'(BURST_BEATS)) <= CRED_W'(DEPTH)) && !tag_full;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    s_axis_tready     = 1'b0;
    m_mem_axi_arvalid = 1'b0;
    accept            = 1'b0;
    reserve           = 1'b0;
    ar_done           = 1'b0;
    case (state_reg)
      IDLE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (can_reserve) begin
          reserve    = 1'b1;
          state_next = WAIT_AR;
        end
      end
      WAIT_AR: begin
        m_mem_axi_arvalid = 1'b1;
        if (m_mem_axi_arready) begin
          ar_done    = 1'b1;
          state_next = page_end ? IDLE : ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_mem_axi_araddr = araddr_reg;

  // Address datapath: page base, running byte offset, burst address.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      base_reg      <= '0;
      off_reg       <= '0;
      page_last_reg <= 1'b0;
      araddr_reg    <= '0;
    end else begin
      if (accept) begin
        base_reg      <= s_axis_tdata[ADDR_WIDTH-1:0];
        off_reg       <= '0;
        page_last_reg <= s_axis_tlast;
      end
      if (reserve) begin
        araddr_reg <= base_reg + ADDR_WIDTH'(off_reg);
      end
      if (ar_done) begin
        off_reg <= off_plus;
      end
    end
  end

  // Credits count beats that have been reserved but not yet handed downstream.
  always_comb begin
    credits_next = credits_reg;
    if (reserve) begin
      credits_next = credits_next + CRED_W'(BURST_BEATS);
    end
    if (out_hs) begin
      credits_next = credits_next - CRED_W'(1);
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      credits_reg <= '0;
    end else begin
      credits_reg <= credits_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO: one bit per issued burst, set when the burst ends a tlast page.
  // Bursts return in order (single ID), so the head tag belongs to the burst
  // currently streaming on R.
  // ---------------------------------------------------------------------------
  logic                    tag_mem_reg [MAX_OUTSTANDING];
  logic [TAG_PTR_W-1:0]    tag_wr_ptr_reg;
  logic [TAG_PTR_W-1:0]    tag_rd_ptr_reg;
  logic [TAG_CNT_W-1:0]    tag_cnt_reg;
  logic                    tag_in;
  logic                    tag_head;
  logic                    tag_pop;

  assign tag_in   = page_last_reg && page_end;
  assign tag_full = (tag_cnt_reg == TAG_CNT_W'(MAX_OUTSTANDING));
  assign tag_pop  = m_mem_axi_rvalid && m_mem_axi_rlast && (tag_cnt_reg != '0);
  assign tag_head = tag_mem_reg[tag_rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
      always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
          tag_mem_reg[gi] <= 1'b0;
        end else if (reserve && (tag_wr_ptr_reg == TAG_PTR_W'(gi))) begin
          tag_mem_reg[gi] <= tag_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      tag_cnt_reg    <= '0;
    end else begin
      if (reserve) begin
        tag_wr_ptr_reg <= (tag_wr_ptr_reg == TAG_PTR_W'(MAX_OUTSTANDING - 1)) ?
                          '0 : tag_wr_ptr_reg + TAG_PTR_W'(1);
      end
      if (tag_pop) begin
        tag_rd_ptr_reg <= (tag_rd_ptr_reg == TAG_PTR_W'(MAX_OUTSTANDING - 1)) ?
                          '0 : tag_rd_ptr_reg + TAG_PTR_W'(1);
      end
      tag_cnt_reg <= tag_cnt_reg + TAG_CNT_W'(reserve) - TAG_CNT_W'(tag_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Data FIFO: RAM array plus a registered output stage. When the RAM is empty
  // and the output stage is free, an R beat bypasses the RAM so it appears on
  // m_axis one cycle after it arrives.
  // ---------------------------------------------------------------------------
  logic [STREAM_WIDTH:0]   data_mem [DEPTH];
  logic [STREAM_WIDTH:0]   out_word_reg;
  logic                    m_valid_reg;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [CNT_W-1:0]        fifo_cnt_reg;

  logic [STREAM_WIDTH:0]   r_word;
  logic                    out_free;
  logic                    fifo_empty;
  logic                    load_mem;
  logic                    bypass;
  logic                    mem_wr;

  assign r_word     = {m_mem_axi_rlast && tag_head, m_mem_axi_rdata};
  assign out_free   = !m_valid_reg || m_axis_tready;
  assign fifo_empty = (fifo_cnt_reg == '0);
  assign load_mem   = out_free && !fifo_empty;
  assign bypass     = out_free && fifo_empty && m_mem_axi_rvalid;
  assign mem_wr     = m_mem_axi_rvalid && !bypass;
  assign out_hs     = m_valid_reg && m_axis_tready;

  // Storage and output word carry no reset so the array maps onto block RAM.
  always_ff @(posedge aclk) begin
    if (mem_wr) begin
      data_mem[wr_ptr_reg] <= r_word;
    end
    if (load_mem) begin
      out_word_reg <= data_mem[rd_ptr_reg];
    end else if (bypass) begin
      out_word_reg <= r_word;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      m_valid_reg  <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (load_mem) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(mem_wr) - CNT_W'(load_mem);
      if (out_free) begin
        m_valid_reg <= !fifo_empty || m_mem_axi_rvalid;
      end
    end
  end

  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = out_word_reg[STREAM_WIDTH-1:0];
  // Gating with valid keeps tlast low after reset while the word is stale.
  assign m_axis_tlast  = m_valid_reg & out_word_reg[STREAM_WIDTH];

  // ---------------------------------------------------------------------------
  // Read-response error flag
  // ---------------------------------------------------------------------------
`ifdef PAGED_STREAM_READER_RRESP_CHECK_EN
  logic rd_error_reg;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      rd_error_reg <= 1'b0;
    end else if (m_mem_axi_rvalid && (m_mem_axi_rresp != 2'b00)) begin
      rd_error_reg <= 1'b1;
    end
  end

  assign rd_error = rd_error_reg;
`else
  assign rd_error = 1'b0;
`endif

  // Inputs that are only partly consumed (ID, upper tdata bits, rresp when
  // the error check is compiled out).
  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_mem_axi_rid, m_mem_axi_rresp, s_axis_tdata};

endmodule

// File: tb/tb_paged_stream_reader.sv
module tb_paged_stream_reader;

  localparam int SW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int PS = 64;
  localparam int BB = 4;
  localparam int MO = 2;
  localparam int BEATS_PER_PAGE = PS / (SW / 8);

`ifdef PAGED_STREAM_READER_RRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [SW-1:0] s_axis_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [SW-1:0] m_axis_tdata;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [IW-1:0] rid = '0;
  logic [SW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic          rd_error;

  always #5 aclk = ~aclk;

  paged_stream_reader #(
    .STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .PAGE_SIZE(PS),
    .BURST_BEATS(BB), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .m_mem_axi_arid(arid), .m_mem_axi_araddr(araddr), .m_mem_axi_arlen(arlen),
    .m_mem_axi_arsize(arsize), .m_mem_axi_arburst(arburst), .m_mem_axi_arlock(arlock),
    .m_mem_axi_arcache(arcache), .m_mem_axi_arprot(arprot),
    .m_mem_axi_arvalid(arvalid), .m_mem_axi_arready(arready),
    .m_mem_axi_rid(rid), .m_mem_axi_rdata(rdata), .m_mem_axi_rresp(rresp),
    .m_mem_axi_rlast(rlast), .m_mem_axi_rvalid(rvalid), .m_mem_axi_rready(rready),
    .rd_error(rd_error)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  typedef struct packed {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_beats[$];
  logic [AW-1:0] exp_ar[$];
  int            beat_cnt = 0;
  int            ar_cnt = 0;

  // Memory model state
  logic [AW-1:0] pend_addr[$];
  int            pend_beat = 0;
  int            ar_delay = 0;
  int            ar_wait = 0;
  bit            ar_held = 1'b0;
  logic [AW-1:0] held_addr = '0;
  int            r_num = 0;
  int            err_beat = 0;
  bit            err_chk = 1'b0;

  // Latency tracking
  int hs_cyc = -1;
  int first_ar_cyc = -1;
  int first_r_cyc = -1;
  int first_m_cyc = -1;

  // Memory slave and output monitor. Runs on the falling edge: everything
  // driven or observed here holds until the next rising edge, so a valid/ready
  // pair seen here is the handshake of that rising edge.
  always @(negedge aclk) begin
    if (reset) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      pend_addr.delete();
      pend_beat = 0;
      ar_wait   = 0;
      ar_held   = 1'b0;
      err_chk   = 1'b0;
    end else begin
      if (err_chk) begin
        check("rd_error_next_cycle", 64'(rd_error), 64'(EXP_ERR));
        err_chk = 1'b0;
      end
      // R channel: one beat per cycle of the oldest accepted burst.
      if (pend_addr.size() > 0) begin
        rvalid = 1'b1;
        rdata  = (pend_addr[0] + 32'(pend_beat * 4)) >> 2;
        rlast  = (pend_beat == BB - 1);
        r_num++;
        rresp  = (r_num == err_beat) ? 2'b10 : 2'b00;
        if (r_num == err_beat) err_chk = 1'b1;
        if (first_r_cyc < 0) first_r_cyc = cyc;
        pend_beat++;
        if (pend_beat == BB) begin
          pend_beat = 0;
          void'(pend_addr.pop_front());
        end
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
      // AR channel with programmable ready delay.
      if (ar_held) begin
        check("arvalid_stable", 64'(arvalid), 64'(1));
        check("araddr_stable", 64'(araddr), 64'(held_addr));
      end
      if (arvalid) begin
        if (first_ar_cyc < 0) first_ar_cyc = cyc;
        arready = (ar_wait >= ar_delay);
        if (arready) begin
          check("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
          if (exp_ar.size() != 0) check("araddr", 64'(araddr), 64'(exp_ar.pop_front()));
          check("arlen", 64'(arlen), 64'(BB - 1));
          check("arsize", 64'(arsize), 64'(2));
          check("arburst", 64'(arburst), 64'(1));
          pend_addr.push_back(araddr);
          ar_cnt++;
          ar_wait = 0;
          ar_held = 1'b0;
        end else begin
          ar_wait++;
          ar_held   = 1'b1;
          held_addr = araddr;
        end
      end else begin
        arready = 1'b0;
      end
      // Output stream.
      if (m_axis_tvalid && first_m_cyc < 0) first_m_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", 64'(exp_beats.size() != 0), 64'(1));
        if (exp_beats.size() != 0) begin
          beat_t b;
          b = exp_beats.pop_front();
          check("tdata", 64'(m_axis_tdata), 64'(b.data));
          check("tlast", 64'(m_axis_tlast), 64'(b.last));
        end
        beat_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_page(input logic [AW-1:0] base, input logic last);
    bit ok;
    for (int i = 0; i < BEATS_PER_PAGE; i++) begin
      beat_t b;
      b.data = (base + 32'(i * 4)) >> 2;
      b.last = last && (i == BEATS_PER_PAGE - 1);
      exp_beats.push_back(b);
    end
    for (int k = 0; k < BEATS_PER_PAGE / BB; k++) exp_ar.push_back(base + 32'(k * BB * 4));
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = base;
    s_axis_tlast  = last;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        ok = 1'b1;
        hs_cyc = cyc;
        break;
      end
    end
    check("s_axis_accept", 64'(ok), 64'(1));
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (beat_cnt < n && k < budget) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check(tag, 64'(beat_cnt), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    check("reset_s_tready", 64'(s_axis_tready), 64'(1));
    check("reset_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("reset_m_tlast", 64'(m_axis_tlast), 64'(0));
    check("reset_arvalid", 64'(arvalid), 64'(0));
    check("reset_rd_error", 64'(rd_error), 64'(0));
    reset = 1'b0;
    repeat (2) tick();

    // 1: single page, latency checks
    beat_cnt = 0; ar_cnt = 0;
    first_ar_cyc = -1; first_r_cyc = -1; first_m_cyc = -1;
    send_page(32'h1000, 1'b1);
    wait_beats("page1_beats", 16, 400);
    check("page1_ar_count", 64'(ar_cnt), 64'(4));
    check("accept_to_arvalid", 64'(first_ar_cyc - hs_cyc), 64'(2));
    check("r_to_m_latency", 64'(first_m_cyc - first_r_cyc), 64'(1));

    // 2: two pages, second accepted while first still streaming
    beat_cnt = 0; ar_cnt = 0;
    send_page(32'h2000, 1'b0);
    send_page(32'h3000, 1'b1);
    check("page2_overlap", 64'(beat_cnt < 16), 64'(1));
    wait_beats("two_page_beats", 32, 800);
    check("two_page_ar_count", 64'(ar_cnt), 64'(8));

    // 3: downstream stalled for 100 cycles
    beat_cnt = 0; ar_cnt = 0;
    m_axis_tready = 1'b0;
    send_page(32'h6000, 1'b1);
    repeat (100) tick();
    check("stall_ar_count", 64'(ar_cnt), 64'(2));
    check("stall_no_beats", 64'(beat_cnt), 64'(0));
    m_axis_tready = 1'b1;
    wait_beats("stall_release_beats", 16, 400);
    check("stall_total_ar", 64'(ar_cnt), 64'(4));

    // 4: arready delayed 5 cycles per burst
    beat_cnt = 0; ar_cnt = 0;
    ar_delay = 5;
    send_page(32'h5000, 1'b1);
    wait_beats("ar_delay_beats", 16, 800);
    check("ar_delay_ar_count", 64'(ar_cnt), 64'(4));
    ar_delay = 0;

    // 5: reset mid-page after 6 beats, then a clean page
    beat_cnt = 0;
    send_page(32'h7000, 1'b1);
    for (int k = 0; k < 400 && beat_cnt < 6; k++) tick();
    check("pre_reset_beats", 64'(beat_cnt >= 6), 64'(1));
    #3 reset = 1'b1;
    #1;
    check("mid_reset_s_tready", 64'(s_axis_tready), 64'(1));
    check("mid_reset_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("mid_reset_m_tlast", 64'(m_axis_tlast), 64'(0));
    check("mid_reset_arvalid", 64'(arvalid), 64'(0));
    check("mid_reset_rd_error", 64'(rd_error), 64'(0));
    exp_beats.delete();
    exp_ar.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    beat_cnt = 0; ar_cnt = 0;
    send_page(32'h4000, 1'b1);
    wait_beats("post_reset_beats", 16, 400);
    check("post_reset_ar_count", 64'(ar_cnt), 64'(4));

    // 6: error response on the third beat
    check("rd_error_before", 64'(rd_error), 64'(0));
    beat_cnt = 0;
    r_num = 0;
    err_beat = 3;
    send_page(32'h8000, 1'b1);
    wait_beats("rresp_beats", 16, 400);
    check("rd_error_sticky", 64'(rd_error), 64'(EXP_ERR));
    err_beat = 0;

    check("exp_ar_drained", 64'(exp_ar.size()), 64'(0));
    check("exp_beats_drained", 64'(exp_beats.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
